// File: rtl/ex_flag_stage.sv
// EX/MEM boundary stage behind the 64-bit add/sub unit.
// Registers the adder result, destination and write-enable into MEM, keeps
// the architectural NZCV register, and resolves B.cond against flags that are
// bypassed from the instruction currently in EX, so a branch right after a
// flag-setting op needs no stall.
module ex_flag_stage #(
    parameter int WIDTH    = 64,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    sum,
    input  logic                of,
    input  logic                carry,
    input  logic                set_flags,
    input  logic [REG_BITS-1:0] rd,
    input  logic                reg_write,
    input  logic                stall,
    input  logic                flush,
    input  logic [3:0]          cond,
    output logic                mem_valid,
    output logic [WIDTH-1:0]    mem_result,
    output logic [REG_BITS-1:0] mem_rd,
    output logic                mem_reg_write,
    output logic [3:0]          flags,
    output logic                cond_taken
);

    // Flag bit positions within NZCV
    localparam int FN = 3;
    localparam int FZ = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    logic       upd_p0;
    logic [3:0] new_flags_p0;
    logic [3:0] eff_flags_p0;

    // Evaluate an ARM condition code against an NZCV nibble.
    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic r;
        n  = f[FN];
        z  = f[FZ];
        cy = f[FC];
        v  = f[FV];
        case (c)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = cy;
            4'b0011: r = ~cy;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = cy & ~z;
            4'b1001: r = ~(cy & ~z);
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = ~(~z & (n == v));
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // A stalled or flushed EX instruction must not touch the flags. Reset
    // deliberately does not gate this, so the bypass stays live during reset.
    assign upd_p0       = in_valid & set_flags & ~stall & ~flush;
    assign new_flags_p0 = {sum[WIDTH-1], (sum == '0), carry, of};
    assign eff_flags_p0 = upd_p0 ? new_flags_p0 : flags;
    assign cond_taken   = eval_cond(cond, eff_flags_p0);

    // ---- EX -> MEM boundary: pipeline register and NZCV register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid     <= 1'b0;
            mem_result    <= '0;
            mem_rd        <= '0;
            mem_reg_write <= 1'b0;
            flags         <= 4'b0000;
        end else begin
            if (flush) begin
                mem_valid     <= 1'b0;
                mem_result    <= '0;
                mem_rd        <= '0;
                mem_reg_write <= 1'b0;
            end else if (!stall) begin
                mem_valid     <= in_valid;
                mem_result    <= sum;
                mem_rd        <= rd;
                mem_reg_write <= reg_write & in_valid;
            end
            if (upd_p0) begin
                flags <= new_flags_p0;
            end
        end
    end

endmodule

// File: tb/tb_ex_flag_stage.sv
// Scoreboard bench for ex_flag_stage: the driver computes expected results from
// a behavioural model and queues them; independent monitors pop and compare.
module tb_ex_flag_stage;

    localparam int WIDTH    = 64;
    localparam int REG_BITS = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic [WIDTH-1:0]    sum;
    logic                of;
    logic                carry;
    logic                set_flags;
    logic [REG_BITS-1:0] rd;
    logic                reg_write;
    logic                stall;
    logic                flush;
    logic [3:0]          cond;
    logic                mem_valid;
    logic [WIDTH-1:0]    mem_result;
    logic [REG_BITS-1:0] mem_rd;
    logic                mem_reg_write;
    logic [3:0]          flags;
    logic                cond_taken;

    ex_flag_stage #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sum(sum), .of(of),
        .carry(carry), .set_flags(set_flags), .rd(rd), .reg_write(reg_write),
        .stall(stall), .flush(flush), .cond(cond), .mem_valid(mem_valid),
        .mem_result(mem_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .flags(flags), .cond_taken(cond_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                  v;
        logic [WIDTH-1:0]    res;
        logic [REG_BITS-1:0] rd;
        bit                  rw;
        logic [3:0]          f;
    } exp_t;

    exp_t rq[$];
    bit   cq[$];

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    exp_t m;
    bit   m_known = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    // Condition evaluation from the architectural table: even codes test a
    // predicate, odd codes are its inverse, code 111x is "always".
    function automatic bit ref_cond(logic [3:0] c, logic [3:0] f);
        bit n, z, cc, v, base;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cc && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return base ^ c[0];
    endfunction

    // Drive one EX cycle, queue expectations, then advance to just after the edge.
    task automatic step(input bit rst, input bit iv, input bit sf, input bit rw,
                        input bit st, input bit fl, input bit cy, input bit ov,
                        input logic [WIDTH-1:0] s, input logic [REG_BITS-1:0] r,
                        input logic [3:0] c);
        bit         upd;
        logic [3:0] nf;
        logic [3:0] eff;
        exp_t       nx;
        reset = rst; in_valid = iv; set_flags = sf; reg_write = rw;
        stall = st; flush = fl; carry = cy; of = ov; sum = s; rd = r; cond = c;

        upd = iv && sf && !st && !fl;
        nf  = {s[WIDTH-1], (s == 0) ? 1'b1 : 1'b0, cy, ov};
        eff = upd ? nf : m.f;
        if (m_known || upd) cq.push_back(ref_cond(c, eff));

        nx = m;
        if (rst) begin
            nx.v = 0; nx.res = 0; nx.rd = 0; nx.rw = 0; nx.f = 4'b0000;
        end else begin
            if (fl) begin
                nx.v = 0; nx.res = 0; nx.rd = 0; nx.rw = 0;
            end else if (!st) begin
                nx.v = iv; nx.res = s; nx.rd = r; nx.rw = rw && iv;
            end
            if (upd) nx.f = nf;
        end
        if (rst || m_known) rq.push_back(nx);
        if (rst) m_known = 1;
        m = nx;
        @(posedge clk);
        #2;
    endtask

    // Monitor for the combinational branch resolution
    always @(negedge clk) begin
        if (cq.size() > 0) check("cond_taken", {63'd0, cond_taken}, {63'd0, cq.pop_front()});
    end

    // Monitor for the registered MEM-stage outputs and flags
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rq.size() > 0) begin
            e = rq.pop_front();
            check("mem_valid",     {63'd0, mem_valid},     {63'd0, e.v});
            check("mem_result",    mem_result,             e.res);
            check("mem_rd",        {59'd0, mem_rd},        {59'd0, e.rd});
            check("mem_reg_write", {63'd0, mem_reg_write}, {63'd0, e.rw});
            check("flags",         {60'd0, flags},         {60'd0, e.f});
        end
    end

    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        m = '{v: 0, res: 0, rd: 0, rw: 0, f: 4'b0000};
        reset = 1; in_valid = 0; set_flags = 0; reg_write = 0; stall = 1; flush = 1;
        carry = 0; of = 0; sum = 0; rd = 0; cond = 0;

        // Reset held two cycles with stall and flush asserted
        step(1, 0, 0, 0, 1, 1, 0, 0, 64'h0, 5'd0, 4'b0000);
        step(1, 0, 0, 0, 1, 1, 0, 0, 64'h0, 5'd0, 4'b0000);
        // SUBS of equal operands: Z=1 C=1, EQ taken through the bypass
        step(0, 1, 1, 1, 0, 0, 1, 0, 64'h0, 5'd5, 4'b0000);
        // Stall with a pending flag update: flags and mem_* hold, EQ still taken
        step(0, 1, 1, 1, 1, 0, 0, 0, MINV, 5'd9, 4'b0000);
        // Flush drops the instruction and leaves flags alone
        step(0, 1, 1, 1, 0, 1, 0, 0, 64'h1234, 5'd3, 4'b0001);
        // Back to flags 0000, then a negative result with LT through the bypass
        step(1, 0, 0, 0, 0, 0, 0, 0, 64'h0, 5'd0, 4'b1011);
        step(0, 1, 1, 1, 0, 0, 0, 0, ONES, 5'd7, 4'b1011);
        // Most-negative value: N=1 Z=0
        step(0, 1, 1, 0, 0, 0, 0, 1, MINV, 5'd1, 4'b1100);
        // set_flags and reg_write without in_valid do nothing architectural
        step(0, 0, 1, 1, 0, 0, 1, 1, 64'h0, 5'd2, 4'b0000);
        // Back-to-back flag setters
        step(0, 1, 1, 1, 0, 0, 1, 0, 64'h5, 5'd4, 4'b1000);
        step(0, 1, 1, 1, 0, 0, 0, 1, 64'h0, 5'd6, 4'b0110);

        // Condition sweep over every reachable NZCV value held in the register
        for (int f = 0; f < 16; f++) begin
            logic [3:0] fv;
            logic [63:0] s;
            fv = f[3:0];
            if (fv[3] && fv[2]) continue;
            s = fv[2] ? 64'h0 : (fv[3] ? MINV | 64'h10 : 64'h10);
            step(0, 1, 1, 0, 0, 0, fv[1], fv[0], s, 5'd0, 4'b1110);
            for (int c = 0; c < 16; c++) begin
                logic [3:0] cv;
                cv = c[3:0];
                step(0, 1, 0, 1, 0, 0, 0, 0, 64'h77, 5'd8, cv);
            end
        end

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [63:0] s;
            case ($urandom_range(0, 5))
                0: s = 64'h0;
                1: s = MINV;
                2: s = ONES;
                default: s = {$urandom, $urandom};
            endcase
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 s, 5'($urandom), 4'($urandom));
        end

        in_valid = 0; set_flags = 0; stall = 0; flush = 0; reset = 0;
        repeat (2) @(posedge clk);
        #3;
        check("rq_drain", 64'(rq.size()), 64'd0);
        check("cq_drain", 64'(cq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
